branch_rs: RTL and testbench
============================

BRANCH_RS -- requirements
Module: branch_rs

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- RS_SIZE, 4, number of entries
- TAG_W, 4, width of the rename tag.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, asynchronous, active-low reset.
- clear, in, 1, synchronous flush on a branch mispredict.
- inValid, in, 1, dispatch request.
- inOp, in, 6, branch opCode (BEQ/BNE/BLT/BGE/BLTU/BGEU).
- inOpO, in, 32, operand O value.
- inValO, in, 1, operand O value is valid.
- inTagO, in, TAG_W, producer tag of operand O.
- inOpT, in, 32, operand T value.
- inValT, in, 1, operand T value is valid.
- inTagT, in, TAG_W, producer tag of operand T.
- inImm, in, 32, branch offset.
- inPC, in, 32, branch PC.
- inBNum, in, 2, branch tag.
- cdbAEn, in, 1, result broadcast from the ALU.
- cdbATag, in, TAG_W, ALU result tag.
- cdbAData, in, 32, ALU result data.
- cdbLEn, in, 1, result broadcast from the LSU.
- cdbLTag, in, TAG_W, LSU result tag.
- cdbLData, in, 32, LSU result data.
- rsFull, out, 1, no free entry.
- BranchWorkEn, out, 1, issue valid to the branch unit.
- operandO, out, 32, issued operand O.
- operandT, out, 32, issued operand T.
- opCode, out, 6, issued opCode.
- imm, out, 32, issued offset.
- PC, out, 32, issued PC.
- bNum, out, 2, issued branch tag.

Function
REQ-003 Each entry SHALL hold: busy, op, two (value, valid, tag) operand triples, imm, PC and bNum.
REQ-004 Dispatch: when inValid=1, clear=0 and at least one entry is free, the block SHALL write the lowest-index free entry at the edge.
REQ-005 A dispatch while all entries are busy SHALL be dropped with no state change; an entry freed by issue in the same cycle SHALL NOT be reused that cycle.
REQ-006 Dispatch forwarding: a dispatched operand with val=0 whose tag matches an enabled CDB in the same cycle SHALL be stored as valid with that CDB's data.
REQ-007 Wakeup: each busy entry operand with val=0 and tag equal to an enabled CDB tag SHALL capture the data and set val=1 at the edge.
REQ-008 If both CDBs match the same operand, the ALU CDB SHALL win.
REQ-009 An entry is ready when busy=1 and both operand valid bits are 1, evaluated on stored state only; a CDB value captured this edge makes the entry ready for the next edge.
REQ-010 Issue: at each edge, if any entry is ready and clear=0, the block SHALL free the lowest-index ready entry and load its fields into the registered outputs with BranchWorkEn=1.
REQ-011 Otherwise BranchWorkEn SHALL be 0 and the data outputs SHALL hold their previous values.
REQ-012 Latency: dispatch at edge k with both operands valid SHALL give BranchWorkEn high in the cycle after edge k+1.
REQ-013 Issue rate SHALL be at most one branch per cycle.
REQ-014 rsFull SHALL be combinational from stored state and equal 1 iff all RS_SIZE entries are busy.
REQ-015 clear SHALL, at the edge, free all entries and force BranchWorkEn=0, with priority over dispatch, wakeup and issue.
REQ-016 Tag comparison SHALL be exact TAG_W-bit equality; an operand with val=1 SHALL ignore CDB traffic.

Reset
REQ-017 On rst=0, asynchronously: all busy bits=0, BranchWorkEn=0, operandO=operandT=imm=PC=0, opCode=0, bNum=0; rsFull=0 follows from state.
REQ-018 Reset asserted mid-operation SHALL discard all entries with no issue in the following cycle; normal operation SHALL resume at the first edge after rst returns to 1.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Ready dispatch: BEQ with O=5 valid, T=5 valid, PC=0x100, imm=8, bNum=1 -> BranchWorkEn=1 two edges later with operandO=operandT=5, PC=0x100, imm=8, bNum=1.
- Wakeup: BLT with O waiting on tag 3; cdbAEn=1, cdbATag=3, cdbAData=0xFFFFFFFF two cycles later -> issue on the next edge with operandO=0xFFFFFFFF.
- Full: 4 dispatches with unready operands -> rsFull=1; a 5th dispatch is dropped; waking entry 2 -> entry 2 issues and rsFull=0.
- Priority: entries 0 and 1 woken by the same CDB edge -> entry 0 issues first, entry 1 on the next edge; both CDBs match one tag -> ALU data is stored.
- Flush: 3 busy entries, clear=1 together with inValid=1 -> all entries freed, no issue, rsFull=0, no new entry written.
- Reset: rst=0 while BranchWorkEn=1 -> BranchWorkEn drops immediately and stays 0 after release until a new dispatch.

Source files
------------

// File: rtl/branch_rs.sv
// Branch reservation station: holds dispatched branches until both operands are
// available, snooping the ALU and LSU result buses, and issues one per cycle.
module branch_rs #(
    parameter int RS_SIZE = 4,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inValid,
    input  logic [5:0]       inOp,
    input  logic [31:0]      inOpO,
    input  logic             inValO,
    input  logic [TAG_W-1:0] inTagO,
    input  logic [31:0]      inOpT,
    input  logic             inValT,
    input  logic [TAG_W-1:0] inTagT,
    input  logic [31:0]      inImm,
    input  logic [31:0]      inPC,
    input  logic [1:0]       inBNum,
    input  logic             cdbAEn,
    input  logic [TAG_W-1:0] cdbATag,
    input  logic [31:0]      cdbAData,
    input  logic             cdbLEn,
    input  logic [TAG_W-1:0] cdbLTag,
    input  logic [31:0]      cdbLData,
    output logic             rsFull,
    output logic             BranchWorkEn,
    output logic [31:0]      operandO,
    output logic [31:0]      operandT,
    output logic [5:0]       opCode,
    output logic [31:0]      imm,
    output logic [31:0]      PC,
    output logic [1:0]       bNum
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] o_vld;
    logic [RS_SIZE-1:0] t_vld;
    logic [5:0]         e_op   [RS_SIZE];
    logic [31:0]        o_val  [RS_SIZE];
    logic [TAG_W-1:0]   o_tag  [RS_SIZE];
    logic [31:0]        t_val  [RS_SIZE];
    logic [TAG_W-1:0]   t_tag  [RS_SIZE];
    logic [31:0]        e_imm  [RS_SIZE];
    logic [31:0]        e_pc   [RS_SIZE];
    logic [1:0]         e_bnum [RS_SIZE];

    logic [RS_SIZE-1:0] ready;
    logic               any_ready;
    logic [IDX_W-1:0]   issue_idx;
    logic [IDX_W-1:0]   free_idx;
    logic               do_issue;
    logic               do_dispatch;

    // ALU bus wins when both buses carry the same tag.
    function automatic logic cdb_hit(input logic [TAG_W-1:0] tag);
        return (cdbAEn && tag == cdbATag) || (cdbLEn && tag == cdbLTag);
    endfunction

    function automatic logic [31:0] cdb_data(input logic [TAG_W-1:0] tag);
        return (cdbAEn && tag == cdbATag) ? cdbAData : cdbLData;
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        ready     = busy & o_vld & t_vld;
        any_ready = |ready;
        issue_idx = '0;
        free_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) issue_idx = IDX_W'(i);
            if (!busy[i]) free_idx  = IDX_W'(i);
        end
    end

    assign rsFull      = &busy;
    assign do_issue    = any_ready && !clear;
    assign do_dispatch = inValid && !clear && !rsFull;

    // NOTE: entry payload is deliberately not reset; busy alone says whether it means anything.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_SIZE; i++) begin
            if (busy[i] && !o_vld[i] && cdb_hit(o_tag[i])) begin
                o_val[i] <= cdb_data(o_tag[i]);
                o_vld[i] <= 1'b1;
            end
            if (busy[i] && !t_vld[i] && cdb_hit(t_tag[i])) begin
                t_val[i] <= cdb_data(t_tag[i]);
                t_vld[i] <= 1'b1;
            end
        end
        if (do_dispatch) begin
            e_op[free_idx]   <= inOp;
            o_val[free_idx]  <= inValO ? inOpO : cdb_data(inTagO);
            o_vld[free_idx]  <= inValO || cdb_hit(inTagO);
            o_tag[free_idx]  <= inTagO;
            t_val[free_idx]  <= inValT ? inOpT : cdb_data(inTagT);
            t_vld[free_idx]  <= inValT || cdb_hit(inTagT);
            t_tag[free_idx]  <= inTagT;
            e_imm[free_idx]  <= inImm;
            e_pc[free_idx]   <= inPC;
            e_bnum[free_idx] <= inBNum;
        end
    end

    // NOTE: non-blocking updates make issue and dispatch both see the pre-edge busy vector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy         <= '0;
            BranchWorkEn <= 1'b0;
            operandO     <= '0;
            operandT     <= '0;
            opCode       <= '0;
            imm          <= '0;
            PC           <= '0;
            bNum         <= '0;
        end else if (clear) begin
            busy         <= '0;
            BranchWorkEn <= 1'b0;
        end else begin
            BranchWorkEn <= do_issue;
            if (do_issue) begin
                busy[issue_idx] <= 1'b0;
                operandO        <= o_val[issue_idx];
                operandT        <= t_val[issue_idx];
                opCode          <= e_op[issue_idx];
                imm             <= e_imm[issue_idx];
                PC              <= e_pc[issue_idx];
                bNum            <= e_bnum[issue_idx];
            end
            // The free slot is taken from pre-edge state, so a slot freed by issue is never it.
            if (do_dispatch) busy[free_idx] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_rs.sv
// Directed bench for branch_rs: hand-computed expectations for dispatch, wakeup,
// full/drop, priority, flush and reset behaviour.
module tb_branch_rs;

    localparam logic [5:0] BEQ  = 6'd1;
    localparam logic [5:0] BNE  = 6'd2;
    localparam logic [5:0] BLT  = 6'd3;
    localparam logic [5:0] BGE  = 6'd4;
    localparam logic [5:0] BLTU = 6'd5;
    localparam logic [5:0] BGEU = 6'd6;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        inValid;
    logic [5:0]  inOp;
    logic [31:0] inOpO;
    logic        inValO;
    logic [3:0]  inTagO;
    logic [31:0] inOpT;
    logic        inValT;
    logic [3:0]  inTagT;
    logic [31:0] inImm;
    logic [31:0] inPC;
    logic [1:0]  inBNum;
    logic        cdbAEn;
    logic [3:0]  cdbATag;
    logic [31:0] cdbAData;
    logic        cdbLEn;
    logic [3:0]  cdbLTag;
    logic [31:0] cdbLData;
    logic        rsFull;
    logic        BranchWorkEn;
    logic [31:0] operandO;
    logic [31:0] operandT;
    logic [5:0]  opCode;
    logic [31:0] imm;
    logic [31:0] PC;
    logic [1:0]  bNum;

    int n_checks = 0;
    int n_errors = 0;

    branch_rs #(.RS_SIZE(4), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .inValid(inValid), .inOp(inOp),
        .inOpO(inOpO), .inValO(inValO), .inTagO(inTagO),
        .inOpT(inOpT), .inValT(inValT), .inTagT(inTagT),
        .inImm(inImm), .inPC(inPC), .inBNum(inBNum),
        .cdbAEn(cdbAEn), .cdbATag(cdbATag), .cdbAData(cdbAData),
        .cdbLEn(cdbLEn), .cdbLTag(cdbLTag), .cdbLData(cdbLData),
        .rsFull(rsFull), .BranchWorkEn(BranchWorkEn),
        .operandO(operandO), .operandT(operandT), .opCode(opCode),
        .imm(imm), .PC(PC), .bNum(bNum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inValid = 1'b0;
        clear   = 1'b0;
        cdbAEn  = 1'b0;
        cdbLEn  = 1'b0;
    endtask

    task automatic drive_dispatch(input logic [5:0] op,
                                  input logic [31:0] o, input logic vo, input logic [3:0] to,
                                  input logic [31:0] t, input logic vt, input logic [3:0] tt,
                                  input logic [31:0] im, input logic [31:0] pc,
                                  input logic [1:0] bn);
        inValid = 1'b1;
        inOp    = op;
        inOpO   = o;
        inValO  = vo;
        inTagO  = to;
        inOpT   = t;
        inValT  = vt;
        inTagT  = tt;
        inImm   = im;
        inPC    = pc;
        inBNum  = bn;
    endtask

    task automatic drive_cdb_a(input logic [3:0] tag, input logic [31:0] data);
        cdbAEn   = 1'b1;
        cdbATag  = tag;
        cdbAData = data;
    endtask

    task automatic drive_cdb_l(input logic [3:0] tag, input logic [31:0] data);
        cdbLEn   = 1'b1;
        cdbLTag  = tag;
        cdbLData = data;
    endtask

    logic [3:0] full_tags [4];

    initial begin
        full_tags[0] = 4'd4;
        full_tags[1] = 4'd4;
        full_tags[2] = 4'd6;
        full_tags[3] = 4'd7;

        rst = 1'b0;
        idle();
        drive_dispatch(6'd0, 0, 1'b0, 0, 0, 1'b0, 0, 0, 0, 0);
        inValid  = 1'b0;
        cdbATag  = '0;
        cdbAData = '0;
        cdbLTag  = '0;
        cdbLData = '0;

        // Reset state
        #2;
        check("rst_full", rsFull, 0);
        check("rst_en", BranchWorkEn, 0);
        check("rst_opo", operandO, 0);
        check("rst_pc", PC, 0);
        check("rst_bnum", bNum, 0);
        #10 rst = 1'b1;
        tick();

        // Ready dispatch: issue two edges after dispatch
        drive_dispatch(BEQ, 5, 1'b1, 0, 5, 1'b1, 0, 8, 32'h100, 2'd1);
        tick();
        idle();
        check("s1_latency", BranchWorkEn, 0);
        tick();
        check("s1_en", BranchWorkEn, 1);
        check("s1_opo", operandO, 5);
        check("s1_opt", operandT, 5);
        check("s1_op", opCode, BEQ);
        check("s1_pc", PC, 32'h100);
        check("s1_imm", imm, 8);
        check("s1_bnum", bNum, 1);
        tick();
        check("s1_drop_en", BranchWorkEn, 0);
        check("s1_hold", operandO, 5);

        // Wakeup on the ALU bus two cycles after dispatch; wrong tag ignored
        drive_dispatch(BLT, 0, 1'b0, 4'd3, 7, 1'b1, 0, 16, 32'h104, 2'd2);
        tick();
        idle();
        drive_cdb_l(4'd2, 32'h55);
        tick();
        idle();
        check("s2_no_wake", BranchWorkEn, 0);
        drive_cdb_a(4'd3, 32'hFFFF_FFFF);
        tick();
        idle();
        check("s2_capture_edge", BranchWorkEn, 0);
        tick();
        check("s2_en", BranchWorkEn, 1);
        check("s2_opo", operandO, 32'hFFFF_FFFF);
        check("s2_opt", operandT, 7);
        check("s2_op", opCode, BLT);
        check("s2_pc", PC, 32'h104);
        tick();

        // Fill all four entries with unready branches
        for (int i = 0; i < 4; i++) begin
            drive_dispatch(BNE, 0, 1'b0, full_tags[i], 32'h10 + i, 1'b1, 0,
                           4 * i, 32'h200 + 4 * i, 2'(i));
            tick();
            idle();
            if (i == 2) check("s3_three_busy", rsFull, 0);
        end
        check("s3_full", rsFull, 1);
        drive_dispatch(BGE, 1, 1'b1, 0, 1, 1'b1, 0, 0, 32'h300, 2'd3);
        tick();
        idle();
        check("s3_still_full", rsFull, 1);
        tick();
        check("s3_dropped", BranchWorkEn, 0);
        drive_cdb_a(4'd6, 32'h22);
        tick();
        idle();
        check("s3_wake_full", rsFull, 1);
        check("s3_wake_en", BranchWorkEn, 0);
        tick();
        check("s3_en", BranchWorkEn, 1);
        check("s3_opo", operandO, 32'h22);
        check("s3_pc", PC, 32'h208);
        check("s3_bnum", bNum, 2);
        check("s3_not_full", rsFull, 0);

        // Entries 0 and 1 woken together: lowest index first
        drive_cdb_a(4'd4, 32'h44);
        tick();
        idle();
        tick();
        check("s4_first_en", BranchWorkEn, 1);
        check("s4_first_pc", PC, 32'h200);
        check("s4_first_opo", operandO, 32'h44);
        tick();
        check("s4_second_en", BranchWorkEn, 1);
        check("s4_second_pc", PC, 32'h204);
        check("s4_second_opt", operandT, 32'h11);
        tick();
        check("s4_idle", BranchWorkEn, 0);

        // Both buses carry the waited tag: ALU data kept
        drive_dispatch(BGEU, 0, 1'b0, 4'd9, 3, 1'b1, 0, 0, 32'h400, 2'd0);
        tick();
        idle();
        drive_cdb_a(4'd9, 32'hAAAA);
        drive_cdb_l(4'd9, 32'hBBBB);
        tick();
        idle();
        tick();
        check("s4_dual_en", BranchWorkEn, 1);
        check("s4_dual_opo", operandO, 32'hAAAA);

        // Forwarding at dispatch; a valid operand ignores a matching bus
        drive_dispatch(BLTU, 0, 1'b0, 4'd8, 4, 1'b1, 4'd0, 0, 32'h404, 2'd1);
        drive_cdb_l(4'd8, 32'h88);
        drive_cdb_a(4'd0, 32'hDEAD);
        tick();
        idle();
        tick();
        check("fwd_en", BranchWorkEn, 1);
        check("fwd_opo", operandO, 32'h88);
        check("fwd_opt", operandT, 4);
        check("fwd_op", opCode, BLTU);

        // clear beats issue of a ready entry
        drive_dispatch(BEQ, 1, 1'b1, 0, 1, 1'b1, 0, 0, 32'h500, 2'd0);
        tick();
        idle();
        clear = 1'b1;
        tick();
        idle();
        check("clr_vs_issue", BranchWorkEn, 0);
        tick();
        check("clr_freed", BranchWorkEn, 0);

        // Flush with three busy entries and a simultaneous dispatch
        drive_dispatch(BNE, 0, 1'b0, 4'd12, 0, 1'b1, 0, 0, 32'h600, 2'd0);
        tick();
        drive_dispatch(BNE, 0, 1'b0, 4'd12, 0, 1'b1, 0, 0, 32'h604, 2'd1);
        tick();
        idle();
        drive_dispatch(BEQ, 2, 1'b1, 0, 2, 1'b1, 0, 0, 32'h608, 2'd2);
        tick();
        idle();
        check("fl_pre_full", rsFull, 0);
        drive_dispatch(BEQ, 3, 1'b1, 0, 3, 1'b1, 0, 0, 32'h60C, 2'd3);
        clear = 1'b1;
        tick();
        idle();
        check("fl_en", BranchWorkEn, 0);
        check("fl_full", rsFull, 0);
        tick();
        check("fl_no_write", BranchWorkEn, 0);
        drive_cdb_a(4'd12, 32'h12);
        drive_cdb_l(4'd7, 32'h77);
        tick();
        idle();
        tick();
        check("fl_no_wake", BranchWorkEn, 0);

        // Reset while issuing
        drive_dispatch(BEQ, 6, 1'b1, 0, 6, 1'b1, 0, 0, 32'h700, 2'd0);
        tick();
        drive_dispatch(BEQ, 7, 1'b1, 0, 7, 1'b1, 0, 0, 32'h704, 2'd1);
        tick();
        idle();
        check("rs_pre_en", BranchWorkEn, 1);
        check("rs_pre_pc", PC, 32'h700);
        #2 rst = 1'b0;
        #1;
        check("rs_async_en", BranchWorkEn, 0);
        check("rs_async_pc", PC, 0);
        check("rs_async_opo", operandO, 0);
        check("rs_async_full", rsFull, 0);
        #2 rst = 1'b1;
        tick();
        check("rs_after1", BranchWorkEn, 0);
        tick();
        check("rs_after2", BranchWorkEn, 0);
        drive_dispatch(BGE, 9, 1'b1, 0, 9, 1'b1, 0, 12, 32'h708, 2'd3);
        tick();
        idle();
        tick();
        check("rs_resume_en", BranchWorkEn, 1);
        check("rs_resume_pc", PC, 32'h708);
        check("rs_resume_op", opCode, BGE);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
